jedro_2_regfile: RTL

Parametrised integer register file for the jedro-2 core: configurable width, register count and number of combinational read ports, one write port, a per-register pending-write scoreboard and a sequential bulk-clear engine. Sits between decode (read/issue) and writeback; x0 is hard-wired to zero.

---
 rtl/jedro_2_pkg.sv | 26 ++
 rtl/jedro_2_scoreboard.sv | 53 +++++
 rtl/jedro_2_regfile.sv | 137 +++++++++++++
 3 files changed

// File: rtl/jedro_2_pkg.sv
// jedro_2_pkg: shared types and constants for the jedro-2 register file.
// Holds the clear-engine state encoding, the default geometry and the
// helper that derives the register address width.
package jedro_2_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_NUM_REGS   = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    // Address bits needed to index num_regs registers (at least one bit)
    function automatic int reg_addr_width(input int num_regs);
        int w;
        w = $clog2(num_regs);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/jedro_2_scoreboard.sv
// jedro_2_scoreboard: per-register pending-write bits.
// A set marks a register as waiting for writeback, a clear retires it, and
// flush wipes every bit. Bit 0 (x0) can never become pending. When set and
// clear hit the same register in one cycle, set wins.
module jedro_2_scoreboard
    import jedro_2_pkg::*;
#(
    parameter int NUM_REGS       = DEFAULT_NUM_REGS,
    parameter int NUM_RP         = 2,
    parameter int REG_ADDR_WIDTH = reg_addr_width(NUM_REGS)
) (
    input  logic                             clk_i,
    input  logic                             rstn_i,
    input  logic                             set_i,
    input  logic [REG_ADDR_WIDTH-1:0]        set_addr_i,
    input  logic                             clr_i,
    input  logic [REG_ADDR_WIDTH-1:0]        clr_addr_i,
    input  logic                             flush_i,
    input  logic [NUM_RP*REG_ADDR_WIDTH-1:0] lookup_addr_i,
    output logic [NUM_RP-1:0]                lookup_busy_o
);

    logic [NUM_REGS-1:0] r_busy;

    // Pending bits: flush has top priority, then clear, then set (set wins)
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_busy <= '0;
        end else if (flush_i) begin
            r_busy <= '0;
        end else begin
            if (clr_i) begin
                r_busy[clr_addr_i] <= 1'b0;
            end
            if (set_i && (set_addr_i != '0)) begin
                r_busy[set_addr_i] <= 1'b1;
            end
        end
    end

    // Combinational lookup of the pending bit for every read port
    always_comb begin
        lookup_busy_o = '0;
        for (int k = 0; k < NUM_RP; k++) begin
            if (lookup_addr_i[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == '0) begin
                lookup_busy_o[k] = 1'b0;
            end else begin
                lookup_busy_o[k] = r_busy[lookup_addr_i[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]];
            end
        end
    end

endmodule

// File: rtl/jedro_2_regfile.sv
// jedro_2_regfile: integer register file of the jedro-2 core.
// NUM_RP combinational read ports, one write port, a pending-write
// scoreboard and a sequential bulk-clear engine. x0 always reads zero.
// Optional feature: define JEDRO_2_REGFILE_BYPASS_EN to forward an accepted
// write to matching read ports in the same cycle.
module jedro_2_regfile
    import jedro_2_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int NUM_REGS       = DEFAULT_NUM_REGS,
    parameter int NUM_RP         = 2,
    parameter int REG_ADDR_WIDTH = reg_addr_width(NUM_REGS)
) (
    input  logic                             clk_i,
    input  logic                             rstn_i,
    input  logic [NUM_RP*REG_ADDR_WIDTH-1:0] rp_addr_i,
    output logic [NUM_RP*DATA_WIDTH-1:0]     rp_data_co,
    output logic [NUM_RP-1:0]                rp_busy_co,
    input  logic [REG_ADDR_WIDTH-1:0]        wpc_addr_i,
    input  logic [DATA_WIDTH-1:0]            wpc_data_i,
    input  logic                             wpc_we_i,
    input  logic                             sb_set_i,
    input  logic [REG_ADDR_WIDTH-1:0]        sb_addr_i,
    input  logic                             clr_req_i,
    output logic                             clr_busy_o,
    output logic                             clr_done_o
);

    localparam logic [REG_ADDR_WIDTH-1:0] LAST_REG = REG_ADDR_WIDTH'(NUM_REGS - 1);

    logic [DATA_WIDTH-1:0]     r_regs [NUM_REGS];
    clr_state_e                r_state;
    logic [REG_ADDR_WIDTH-1:0] r_cnt;
    logic                      r_busy;
    logic                      r_done;

    logic                      w_idle;
    logic                      w_wr_acc;
    logic                      w_set_acc;
    logic                      w_flush;
    logic [NUM_RP-1:0]         w_sb_busy;

    assign w_idle    = (r_state == IDLE);
    assign w_wr_acc  = wpc_we_i && (wpc_addr_i != '0) && w_idle;
    assign w_set_acc = sb_set_i && (sb_addr_i != '0) && w_idle;
    assign w_flush   = w_idle && clr_req_i;

    assign clr_busy_o = r_busy;
    assign clr_done_o = r_done;

    // Clear engine: walk x1..x(NUM_REGS-1), then pulse done for one cycle
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (clr_req_i) begin
                        r_state <= CLEAR;
                        r_cnt   <= REG_ADDR_WIDTH'(1);
                        r_busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (r_cnt == LAST_REG) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + REG_ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Register storage: the clear engine owns the array while active
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_state == CLEAR) begin
            r_regs[r_cnt] <= '0;
        end else if (w_wr_acc) begin
            r_regs[wpc_addr_i] <= wpc_data_i;
        end
    end

    jedro_2_scoreboard #(
        .NUM_REGS       (NUM_REGS),
        .NUM_RP         (NUM_RP),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_scoreboard (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .set_i         (w_set_acc),
        .set_addr_i    (sb_addr_i),
        .clr_i         (w_wr_acc),
        .clr_addr_i    (wpc_addr_i),
        .flush_i       (w_flush),
        .lookup_addr_i (rp_addr_i),
        .lookup_busy_o (w_sb_busy)
    );

    // Read ports: stored value (x0 forced to zero), optionally write-forwarded
    always_comb begin
        rp_data_co = '0;
        rp_busy_co = '0;
        for (int k = 0; k < NUM_RP; k++) begin
            if (rp_addr_i[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == '0) begin
                rp_data_co[k*DATA_WIDTH +: DATA_WIDTH] = '0;
                rp_busy_co[k] = 1'b0;
`ifdef JEDRO_2_REGFILE_BYPASS_EN
            end else if (w_wr_acc && (rp_addr_i[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == wpc_addr_i)) begin
                rp_data_co[k*DATA_WIDTH +: DATA_WIDTH] = wpc_data_i;
                rp_busy_co[k] = w_set_acc && (sb_addr_i == wpc_addr_i);
`endif
            end else begin
                rp_data_co[k*DATA_WIDTH +: DATA_WIDTH] = r_regs[rp_addr_i[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]];
                rp_busy_co[k] = w_sb_busy[k];
            end
        end
    end

endmodule
